// File: rtl/spi_frame_pkg.sv
// Shared frame constants, FSM state type and width helpers for the SPI register slave.
package spi_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WDATA,
    ST_RDATA,
    ST_DONE
  } state_t;

  localparam int HDR_BITS   = 1 + 16;
  localparam int FRAME_BITS = HDR_BITS + 32;
  localparam logic RW_WRITE = 1'b1;

  function automatic int hdr_bits(input int addr_width);
    return 1 + addr_width;
  endfunction

endpackage

// File: rtl/spi_reg_slave_if.sv
// SPI pins plus register-bus strobes between the serial master, the slave and the register file.
interface spi_reg_slave_if
  import spi_frame_pkg::*;
#(
  parameter int ADDR_WIDTH = HDR_BITS - 1,
  parameter int DATA_WIDTH = FRAME_BITS - HDR_BITS
);
  logic                  sclk;
  logic                  cs;
  logic                  mosi;
  logic                  miso;
  logic                  reg_wr;
  logic                  reg_rd;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic [DATA_WIDTH-1:0] reg_rdata;
  logic                  frame_err;

  modport slave (
    input  sclk, cs, mosi, reg_rdata,
    output miso, reg_wr, reg_rd, reg_addr, reg_wdata, frame_err
  );

  modport master (
    output sclk, cs, mosi, reg_rdata,
    input  miso, reg_wr, reg_rd, reg_addr, reg_wdata, frame_err
  );
endinterface

// File: rtl/spi_edge_sync.sv
// Synchronizes an async level and emits registered one-cycle rise/fall pulses.
// Pulses appear SYNC_STAGES+1 clk cycles after the pin changes.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= w_s;
      r_rise <= w_s & ~r_prev;
      r_fall <= ~w_s & r_prev;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;
endmodule

// File: rtl/spi_reg_slave.sv
// Mode-0 SPI slave: decodes {rw, addr, data} frames into single-cycle register reads/writes.
// Strobes fire 1 clk after the detected 17th (read) or 49th (write) sclk rise.
module spi_reg_slave
  import spi_frame_pkg::*;
#(
  parameter int ADDR_WIDTH  = HDR_BITS - 1,
  parameter int DATA_WIDTH  = FRAME_BITS - HDR_BITS,
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst_n,
  spi_reg_slave_if.slave bus
);
  localparam int L_HDR   = hdr_bits(ADDR_WIDTH);
  localparam int L_FRAME = L_HDR + DATA_WIDTH;
  localparam int CNT_W   = $clog2(L_FRAME + 1);

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   w_cs;
  logic                   w_mosi;
  logic                   w_sclk_rise;
  logic                   w_sclk_fall;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  // Holds every frame bit but the last; the final bit is taken straight from mosi.
  logic [L_FRAME-2:0]     r_rx;
  logic [DATA_WIDTH-1:0]  r_tx;
  logic                   r_miso;
  logic                   r_reg_wr;
  logic                   r_reg_rd;
  logic                   r_rd_d;
  logic                   r_frame_err;
  logic [ADDR_WIDTH-1:0]  r_reg_addr;
  logic [DATA_WIDTH-1:0]  r_reg_wdata;

  logic [L_FRAME-2:0]     w_rx_next;
  logic                   w_last_hdr;
  logic                   w_last_bit;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (bus.sclk),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // cs resets to the deasserted level so a cs held low through reset reads as a new frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
    end
  end

  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_rx_next  = {r_rx[L_FRAME-3:0], w_mosi};
  assign w_last_hdr = (r_cnt == CNT_W'(L_HDR - 1));
  assign w_last_bit = (r_cnt == CNT_W'(L_FRAME - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_miso      <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_reg_rd    <= 1'b0;
      r_rd_d      <= 1'b0;
      r_frame_err <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
    end else begin
      r_reg_wr    <= 1'b0;
      r_reg_rd    <= 1'b0;
      r_frame_err <= 1'b0;
      r_rd_d      <= r_reg_rd;
      if (r_rd_d) r_tx <= bus.reg_rdata;
      if (w_cs) r_miso <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (!w_cs) begin
            r_state <= ST_HDR;
            r_cnt   <= '0;
            r_rx    <= '0;
          end
        end
        ST_HDR: begin
          if (w_cs) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (w_sclk_rise) begin
            r_rx  <= w_rx_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last_hdr) begin
              if (r_rx[L_HDR-2] == RW_WRITE) begin
                r_state <= ST_WDATA;
              end else begin
                r_reg_rd   <= 1'b1;
                r_reg_addr <= w_rx_next[ADDR_WIDTH-1:0];
                r_state    <= ST_RDATA;
              end
            end
          end
        end
        ST_WDATA: begin
          if (w_cs) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (w_sclk_rise) begin
            r_rx  <= w_rx_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last_bit) begin
              r_reg_wr    <= (r_rx[L_FRAME-2] == RW_WRITE);
              r_reg_addr  <= r_rx[DATA_WIDTH-1 +: ADDR_WIDTH];
              r_reg_wdata <= w_rx_next[DATA_WIDTH-1:0];
              r_state     <= ST_DONE;
            end
          end
        end
        ST_RDATA: begin
          if (w_cs) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (w_sclk_fall) begin
            r_miso <= r_tx[DATA_WIDTH-1];
            r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
            r_cnt  <= r_cnt + 1'b1;
            if (w_last_bit) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (w_cs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.miso      = r_miso;
  assign bus.reg_wr    = r_reg_wr;
  assign bus.reg_rd    = r_reg_rd;
  assign bus.reg_addr  = r_reg_addr;
  assign bus.reg_wdata = r_reg_wdata;
  assign bus.frame_err = r_frame_err;
endmodule
